polar_encoder_seq: RTL and testbench
====================================

POLAR_ENCODER_SEQ -- requirements
Module: polar_encoder_seq

Interface
REQ-001 Parameter N, default 8, code length; SHALL be a power of two, at least 2.
REQ-002 Parameter K, default 4, number of information bits per frame.
REQ-003 Parameter FROZEN, N bits, default 8'h17; bit i = 1 marks u[i] as frozen (forced 0). Popcount of ~FROZEN SHALL equal K.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  info_bits holds a valid frame.
REQ-007 in_ready  output  1  block can accept a frame.
REQ-008 info_bits  input  K (unpacked, info_bits[K])  information bits; index 0 is the first information position.
REQ-009 out_valid  output  1  data holds a finished codeword.
REQ-010 out_ready  input  1  downstream channel stage consumes the codeword.
REQ-011 data  output  1 bit x N (unpacked, data[N])  codeword bit x_j on data[j], natural (non-bit-reversed) order; feeds the channel stage's data[N] input directly.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ENC, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, load u and go to ENC with stage counter s=0.
REQ-014 Load mapping: u[i]=0 for frozen i; non-frozen positions, taken in ascending index order, receive info_bits[0], info_bits[1], ... in turn.
REQ-015 ENC: each cycle applies butterfly stage s to all i with bit s of i clear: u[i] <= u[i] ^ u[i+2^s]; other u[i] unchanged; s increments.
REQ-016 After the edge applying stage log2(N)-1, the FSM SHALL enter DONE; result equals u x F^(tensor log2 N), F=[[1,0],[1,1]], i.e. x_j = XOR of u_i over all i with (j & ~i)==0.
REQ-017 Latency: out_valid SHALL rise exactly log2(N) edges after the accepting edge (3 for N=8).
REQ-018 DONE: out_valid=1, in_ready=0; data SHALL hold stable until out_valid&&out_ready; on that edge go to IDLE.
REQ-019 No frame SHALL be accepted in ENC or DONE; in_valid there is ignored, with no buffering.
REQ-020 data SHALL reflect the u register in all states; the value is only meaningful while out_valid=1.
REQ-021 Stage counter width SHALL be clog2(log2 N) with a minimum of 1; no wrap beyond log2(N)-1.
REQ-022 If out_ready is already 1 when DONE is entered, the handshake completes on the next edge; minimum frame period is log2(N)+2 cycles.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, s=0, all u bits 0, out_valid=0; in_ready=1 on the following cycle.
REQ-024 Reset during ENC or DONE SHALL discard the frame in progress; no partial codeword is ever flagged valid.
REQ-025 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-026 A shared package polar_pkg SHALL hold: the FSM state enum, a LOG2N constant function, and a function building the info-position map from FROZEN and K.
REQ-027 One sub-module, polar_butterfly_stage (combinational; inputs u[N] and stage index; output next u[N]), SHALL implement REQ-015.
REQ-028 Elaboration SHALL fail (assertion) if N is not a power of two or popcount(~FROZEN) != K.

Verification (N=8, K=4, FROZEN=8'h17, info positions 3,5,6,7)
REQ-029 info_bits={1,1,1,1}, accept -> 3 edges later out_valid=1 with data[0..7]=0,1,1,0,1,0,0,1.
REQ-030 info_bits[0]=1 only -> data=1,1,1,1,0,0,0,0; info_bits[3]=1 only -> data all 1; all zeros -> data all 0.
REQ-031 out_ready held 0 for 5 cycles in DONE -> data and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-032 in_valid pulsed during ENC with different bits -> ignored; output matches the originally accepted frame.
REQ-033 rst asserted in the second ENC cycle -> next cycle IDLE, out_valid=0, u all 0; a subsequent frame encodes correctly.
REQ-034 Back-to-back frames with out_ready tied 1 -> one codeword every 5 cycles, each matching the golden x = u*F^(tensor 3).

Source files
------------

// File: rtl/polar_pkg.sv
// polar_pkg -- shared definitions for the sequential polar encoder.
//   polar_state_e : encoder FSM states (IDLE / ENC / DONE)
//   log2n()       : exact log2 of a power-of-two code length
//   is_pow2()     : true when n is a power of two and at least 2
//   num_info()    : number of non-frozen positions in a frozen mask
//   info_rank()   : info-position map; for codeword position pos, the
//                   index into info_bits that lands there, or -1 if the
//                   position is frozen
// Frozen masks are passed zero-extended to MAX_N bits so the helpers work
// for any code length the encoder is built with.
package polar_pkg;

  localparam int MAX_N = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } polar_state_e;

  function automatic int log2n(input int n);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < n) r = b + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int num_info(input logic [MAX_N-1:0] frozen, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && !frozen[i]) cnt++;
    end
    return cnt;
  endfunction

  // Non-frozen positions are filled in ascending index order, so the rank
  // of a position is the number of non-frozen positions below it.
  function automatic int info_rank(input logic [MAX_N-1:0] frozen, input int n,
                                   input int pos);
    int rank;
    rank = 0;
    if (pos < 0 || pos >= n || frozen[pos]) return -1;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < pos && !frozen[i]) rank++;
    end
    return rank;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// polar_butterfly_stage -- one butterfly layer of the polar transform.
//   u_i   [N]     current working vector
//   stage [SW]    butterfly stage index s (0 .. log2(N)-1)
//   u_o   [N]     u_i with u[i] ^= u[i + 2^s] for every i whose bit s is 0
// Purely combinational; the encoder registers the result.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 2
) (
  input  logic          u_i [N],
  input  logic [SW-1:0] stage,
  output logic          u_o [N]
);

  localparam int LOG2N = log2n(N);

  // Loop over every legal stage with constant strides so each XOR pair is
  // a fixed wire pair; the runtime stage index only selects among them.
  always_comb begin
    u_o = u_i;
    for (int s = 0; s < LOG2N; s++) begin
      if (int'(stage) == s) begin
        for (int i = 0; i < N; i++) begin
          if (((i >> s) & 1) == 0) u_o[i] = u_i[i] ^ u_i[i + (1 << s)];
        end
      end
    end
  end

endmodule

// File: rtl/polar_encoder_seq.sv
// polar_encoder_seq -- sequential polar encoder, one butterfly stage per cycle.
//   clk, rst            clock; synchronous active-high reset
//   in_valid / in_ready frame handshake; info_bits[K] carries the frame
//   out_valid/out_ready codeword handshake; data[N] is x in natural order
// A frame is scattered into the non-frozen positions of u, transformed in
// place over log2(N) cycles, then held until the downstream stage takes it.
module polar_encoder_seq
  import polar_pkg::*;
#(
  parameter int           N      = 8,
  parameter int           K      = 4,
  parameter logic [N-1:0] FROZEN = 8'h17
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic info_bits [K],
  output logic out_valid,
  input  logic out_ready,
  output logic data [N]
);

  localparam int                 LOG2N      = log2n(N);
  localparam int                 SW         = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam logic [MAX_N-1:0]   FROZEN_EXT = MAX_N'(FROZEN);
  localparam logic [SW-1:0]      S_LAST     = SW'(LOG2N - 1);

  if (!is_pow2(N) || N > MAX_N) begin : g_bad_n
    $fatal(1, "polar_encoder_seq: N must be a power of two, 2..MAX_N");
  end
  if (num_info(FROZEN_EXT, N) != K) begin : g_bad_k
    $fatal(1, "polar_encoder_seq: popcount(~FROZEN) must equal K");
  end

  polar_state_e  state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic          u_q   [N];
  logic          u_d   [N];
  logic          u_nxt [N];
  logic          load_u [N];

  // Frozen positions are tied low; info positions pick their bit by rank.
  for (genvar i = 0; i < N; i++) begin : g_load
    localparam int RANK = info_rank(FROZEN_EXT, N, i);
    if (RANK < 0 || RANK >= K) begin : g_frozen
      assign load_u[i] = 1'b0;
    end else begin : g_info
      assign load_u[i] = info_bits[RANK];
    end
  end

  polar_butterfly_stage #(
    .N  (N),
    .SW (SW)
  ) u_stage (
    .u_i   (u_q),
    .stage (s_q),
    .u_o   (u_nxt)
  );

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    u_d       = u_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          u_d     = load_u;
          s_d     = '0;
          state_d = ST_ENC;
        end
      end
      ST_ENC: begin
        u_d = u_nxt;
        if (s_q == S_LAST) begin
          s_d     = '0;
          state_d = ST_DONE;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      u_q     <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      u_q     <= u_d;
    end
  end

  assign data = u_q;

endmodule

// File: tb/tb_polar_encoder_seq.sv
module tb_polar_encoder_seq;

  localparam int N = 8;
  localparam int K = 4;
  localparam int POS [K] = '{3, 5, 6, 7};

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic info_bits [K];
  logic out_valid;
  logic out_ready;
  logic data [N];

  int total;
  int bad;
  int cyc;
  logic [7:0] exp_q [$];
  int         out_cyc_q [$];
  bit         b2b_phase;

  polar_encoder_seq #(
    .N      (N),
    .K      (K),
    .FROZEN (8'h17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .info_bits (info_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden model: u built from the known info positions, x_j = XOR of u_i
  // over every i that contains all bits of j.
  function automatic logic [7:0] golden(input logic [3:0] b);
    logic [7:0] u;
    logic [7:0] x;
    u = '0;
    for (int k = 0; k < K; k++) u[POS[k]] = b[k];
    x = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((j & ~i) == 0) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  function automatic logic [7:0] pack_data();
    logic [7:0] r;
    for (int j = 0; j < N; j++) r[j] = data[j];
    return r;
  endfunction

  function automatic logic [3:0] pack_info();
    logic [3:0] r;
    for (int k = 0; k < K; k++) r[k] = info_bits[k];
    return r;
  endfunction

  task automatic set_bits(input logic [3:0] b);
    for (int k = 0; k < K; k++) info_bits[k] = b[k];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(golden(pack_info()));
      if (out_valid && out_ready) begin
        if (b2b_phase) out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_out", 32'(pack_data()), 32'hFFFF_FFFF);
        end else begin
          check_eq("sb_data", 32'(pack_data()), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Send one frame from IDLE, then measure edges until out_valid.
  task automatic send_and_wait(input logic [3:0] b, input string tag);
    int lat;
    set_bits(b);
    in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 3);
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    cyc = 0;
    b2b_phase = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_bits(4'b0000);
    step();
    step();
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(pack_data()), 32'd0);

    // all ones, with downstream stalled for 5 cycles
    out_ready = 1'b0;
    send_and_wait(4'b1111, "ones");
    check_eq("ones_data", 32'(pack_data()), 32'h96);
    for (int c = 0; c < 5; c++) begin
      set_bits(4'b0001);
      in_valid = (c == 2);
      step();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_data", 32'(pack_data()), 32'h96);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
    check_eq("release_out_valid", 32'(out_valid), 32'd0);

    send_and_wait(4'b0001, "b0");
    check_eq("b0_data", 32'(pack_data()), 32'h0F);
    step();
    send_and_wait(4'b1000, "b3");
    check_eq("b3_data", 32'(pack_data()), 32'hFF);
    step();
    send_and_wait(4'b0000, "zero");
    check_eq("zero_data", 32'(pack_data()), 32'h00);
    step();

    // in_valid pulsed during ENC must be ignored
    set_bits(4'b0001);
    in_valid = 1'b1;
    step();
    set_bits(4'b1000);
    step();
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("ignore_data", 32'(pack_data()), 32'h0F);
    step();

    // reset in the second ENC cycle discards the frame
    set_bits(4'b1111);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_data", 32'(pack_data()), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("midrst_quiet", 32'(out_valid), 32'd0);
    end
    send_and_wait(4'b0110, "postrst");
    check_eq("postrst_data", 32'(pack_data()), 32'(golden(4'b0110)));
    step();

    // back-to-back frames, out_ready tied high
    b2b_phase = 1'b1;
    in_valid = 1'b1;
    for (int f = 0; f < 6; f++) begin
      set_bits(4'($urandom_range(0, 15)));
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) check_eq("b2b_accept_timeout", n, 0);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    step();
    b2b_phase = 1'b0;
    check_eq("b2b_count", out_cyc_q.size(), 6);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check_eq("b2b_period", out_cyc_q[i] - out_cyc_q[i-1], 5);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
